// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: valid/ready front-end that launches one multiply/divide at a time on the iterative engine.
//   req_*  : request channel (op 1=mul 0=div, operands, tag); req_ready high only in IDLE
//   core_* : engine control (start pulse, m_d, operands) and status/result (ready, hi, lo)
//   rsp_*  : response channel (hi, lo, tag, divide-by-zero, watchdog error)
module muldiv_sequencer #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  parameter int WDOG  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             core_start,
  output logic             core_m_d,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_hi,
  input  logic [WIDTH-1:0] core_lo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dz,
  output logic             rsp_err
);
  localparam int WW = $clog2(WDOG + 1);
  // abort on the WDOG-th cycle spent in ACK+BUSY
  localparam logic [WW-1:0] WLIM = WW'(WDOG - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, BUSY, RESP} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wdog;
  logic accept, dz, waiting, abort, done;
  assign accept  = req_valid & req_ready;
  assign dz      = ~req_op & (req_b == '0);
  assign waiting = (state == ACK) | (state == BUSY);
  assign abort   = waiting & (wdog == WLIM);
  assign done    = (state == BUSY) & core_ready;
  always_comb begin
    state_nxt  = state;
    req_ready  = state == IDLE;
    core_start = state == LAUNCH;
    case (state)
      IDLE:    state_nxt = accept ? (dz ? RESP : LAUNCH) : IDLE;
      LAUNCH:  state_nxt = ACK;
      // engine still reports ready in the start cycle, so ACK only looks for the falling edge
      ACK:     state_nxt = abort ? RESP : (core_ready ? ACK : BUSY);
      BUSY:    state_nxt = (abort | core_ready) ? RESP : BUSY;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wdog      <= '0;
      core_m_d  <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_hi    <= '0;
      rsp_lo    <= '0;
      rsp_tag   <= '0;
      rsp_dz    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= state_nxt == RESP;
      wdog      <= (state == LAUNCH) ? '0 : waiting ? wdog + 1'b1 : wdog;
      if (accept) begin
        core_m_d <= req_op;
        core_a   <= req_a;
        core_b   <= req_b;
        rsp_tag  <= req_tag;
      end
      if (accept & dz) begin
        rsp_hi  <= req_a;
        rsp_lo  <= '1;
        rsp_dz  <= 1'b1;
        rsp_err <= 1'b0;
      end else if (abort) begin
        rsp_hi  <= '0;
        rsp_lo  <= '0;
        rsp_dz  <= 1'b0;
        rsp_err <= 1'b1;
      end else if (done) begin
        rsp_hi  <= core_hi;
        rsp_lo  <= core_lo;
        rsp_dz  <= 1'b0;
        rsp_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with a behavioural iterative engine.
module tb_muldiv_sequencer;
  localparam int WIDTH = 64;
  localparam int TAG_W = 4;
  localparam int WDOG  = 255;
  typedef struct {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             err;
    int               starts;
    int               lat;
    bit               wd;
  } exp_t;
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_op = 1'b0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             core_start;
  logic             core_m_d;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_ready;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_hi;
  logic [WIDTH-1:0] rsp_lo;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;
  logic             rsp_err;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc = 0;
  int rise = 0;
  int hs_cyc = 0;
  int starts = 0;
  int hold_bad = 0;
  bit inflight = 0;
  bit prev_valid = 0;
  bit stuck = 0;
  int ecnt = 0;
  logic [2*WIDTH-1:0] prod;
  exp_t q[$];

  muldiv_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .WDOG(WDOG)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .core_start(core_start), .core_m_d(core_m_d), .core_a(core_a), .core_b(core_b),
    .core_ready(core_ready), .core_hi(core_hi), .core_lo(core_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_tag(rsp_tag), .rsp_dz(rsp_dz), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine: busy for WIDTH+1 cycles after an accepted start; results decoded live from its inputs
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else if (core_start && ecnt == 0 && !stuck) ecnt <= WIDTH + 1;
    else if (ecnt != 0) ecnt <= ecnt - 1;
  end
  assign core_ready = ecnt == 0;
  always_comb begin
    prod    = {{WIDTH{1'b0}}, core_a} * {{WIDTH{1'b0}}, core_b};
    core_hi = core_m_d ? prod[2*WIDTH-1:WIDTH] : (core_b == '0 ? '0 : core_a % core_b);
    core_lo = core_m_d ? prod[WIDTH-1:0] : (core_b == '0 ? '0 : core_a / core_b);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      inflight = 0;
      prev_valid = 0;
    end else begin
      if (inflight && q.size() > 0 &&
          (core_m_d !== q[0].op || core_a !== q[0].a || core_b !== q[0].b)) hold_bad++;
      if (req_valid && req_ready) begin
        acc = cyc;
        starts = 0;
        hold_bad = 0;
        inflight = 1;
      end
      if (core_start) starts++;
      if (rsp_valid && !prev_valid) rise = cyc;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        inflight = 0;
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_hi", rsp_hi, e.hi);
          chk("rsp_lo", rsp_lo, e.lo);
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_dz", rsp_dz, e.dz);
          chk("rsp_err", rsp_err, e.err);
          chk("start_count", 128'(starts), 128'(e.starts));
          chk("core_hold", 128'(hold_bad), 0);
          if (e.wd) chk("wdog_latency", 128'(rise - acc >= WDOG + 2 && rise - acc <= WDOG + 3), 1);
          else chk("latency", 128'(rise - acc), 128'(e.lat));
        end
      end
    end
  end

  function automatic exp_t mk(input logic op, input logic [WIDTH-1:0] a, b, hi, lo,
                              input logic [TAG_W-1:0] tag);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.hi = hi; e.lo = lo; e.tag = tag;
    e.dz = 1'b0; e.err = 1'b0; e.starts = 1; e.lat = 68; e.wd = 0;
    return e;
  endfunction

  task automatic present(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
    req_op = e.op; req_a = e.a; req_b = e.b; req_tag = e.tag; req_valid = 1'b1;
  endtask

  task automatic await_accept();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 128'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic run(input exp_t e);
    present(e);
    await_accept();
    wait_done();
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra, rb, s_hi, s_lo;
    logic [TAG_W-1:0] s_tag;
    int bad, n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_start", core_start, 0);

    run(mk(1'b1, 64'd3, 64'd5, 64'd0, 64'd15, 4'd2));
    run(mk(1'b0, 64'd100, 64'd7, 64'd2, 64'd14, 4'd3));
    e = mk(1'b0, 64'd9, 64'd0, 64'd9, '1, 4'd4);
    e.dz = 1'b1; e.starts = 0; e.lat = 1;
    run(e);

    stuck = 1;
    e = mk(1'b1, 64'd4, 64'd5, 64'd0, 64'd0, 4'd7);
    e.err = 1'b1; e.wd = 1;
    run(e);
    stuck = 0;
    run(mk(1'b1, 64'd2, 64'd2, 64'd0, 64'd4, 4'd8));

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> (i * 12);
      if (i[0]) run(mk(1'b1, ra, rb, 64'((128'(ra) * 128'(rb)) >> 64), ra * rb, 4'(i + 10)));
      else run(mk(1'b0, ra, rb, ra % rb, ra / rb, 4'(i + 10)));
    end

    rsp_ready = 1'b0;
    present(mk(1'b1, 64'd11, 64'd13, 64'd0, 64'd143, 4'd5));
    await_accept();
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    s_hi = rsp_hi; s_lo = rsp_lo; s_tag = rsp_tag;
    present(mk(1'b0, 64'd1000, 64'd33, 64'd10, 64'd30, 4'd6));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_hi !== s_hi || rsp_lo !== s_lo || rsp_tag !== s_tag) bad++;
    end
    chk("bp_hold", 128'(bad), 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    await_accept();
    chk("bp_accept_gap", 128'(acc - hs_cyc), 1);
    wait_done();

    present(mk(1'b1, 64'd20, 64'd30, 64'd0, 64'd600, 4'd9));
    await_accept();
    n = 0;
    while (cyc < acc + 30 && n < 100) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_core_m_d", core_m_d, 0);
    chk("mid_rst_core_a", core_a, 0);
    chk("mid_rst_rsp_lo", rsp_lo, 0);
    chk("mid_rst_rsp_tag", rsp_tag, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_core_start", core_start, 0);
    chk("rel_req_ready", req_ready, 1);
    run(mk(1'b1, 64'd6, 64'd7, 64'd0, 64'd42, 4'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
